// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and its consumers:
// color_mapper (DrawX/DrawY/Blank) and the VGA connector (hs/vs).
interface vga_timing_gen_if;
  logic       pixel_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       Blank;
  logic       frame_start;
  logic       vblank;

  modport master (
    output pixel_en, DrawX, DrawY, hs, vs, Blank, frame_start, vblank
  );

  modport slave (
    input  pixel_en, DrawX, DrawY, hs, vs, Blank, frame_start, vblank
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, h/v counters and decoded
// sync/blank/frame markers, every output registered.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic in_span(logic [9:0] v, logic [9:0] lo, logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [DIV_W-1:0] div;
  logic             div_wrap;
  logic             h_wrap;
  logic             frame_wrap;
  logic [9:0]       hc_nxt;
  logic [9:0]       vc_nxt;

  // Next raster position; decode below uses it so sync/blank never lag the coordinates.
  always_comb begin
    div_wrap   = (div == DIV_LAST);
    h_wrap     = (vga.DrawX == H_LAST);
    frame_wrap = h_wrap && (vga.DrawY == V_LAST);
    hc_nxt     = h_wrap ? 10'd0 : vga.DrawX + 10'd1;
    vc_nxt     = vga.DrawY;
    if (h_wrap) begin
      vc_nxt = (vga.DrawY == V_LAST) ? 10'd0 : vga.DrawY + 10'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div             <= '0;
      vga.pixel_en    <= 1'b0;
      vga.DrawX       <= 10'd0;
      vga.DrawY       <= 10'd0;
      vga.hs          <= 1'b1;
      vga.vs          <= 1'b1;
      vga.Blank       <= 1'b1;
      vga.frame_start <= 1'b0;
      vga.vblank      <= 1'b0;
    end else begin
      div             <= div_wrap ? '0 : div + DIV_W'(1);
      vga.pixel_en    <= div_wrap;
      vga.frame_start <= div_wrap && frame_wrap;
      if (div_wrap) begin
        vga.DrawX  <= hc_nxt;
        vga.DrawY  <= vc_nxt;
        vga.hs     <= !in_span(hc_nxt, HS_START, HS_END);
        vga.vs     <= !in_span(vc_nxt, VS_START, VS_END);
        vga.Blank  <= (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
        vga.vblank <= (vc_nxt >= V_ACT);
      end
    end
  end

endmodule
